// File: rtl/lfsr_div_engine.sv
// Serial Galois-LFSR division engine: divides a latched K-bit word MSB-first by POLY,
// BPC bits per clock, and presents the W-bit remainder with a start/busy/done handshake.
module lfsr_div_engine #(
    parameter int             W    = 24,
    parameter logic [W-1:0]   POLY = 24'h884110,
    parameter int             K    = 40,
    parameter int             BPC  = 1,
    parameter logic [W-1:0]   INIT = '0,
    parameter int             CW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [K-1:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic [W-1:0]  rem_out,
    output logic          rem_zero
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CW-1:0] BPC_C = CW'(BPC);
    localparam logic [CW-1:0] K_C   = CW'(K);

    state_t          state_reg;
    logic [K-1:0]    word_reg;
    logic [W-1:0]    rem_next;
    logic            step_fb;
    logic [CW-1:0]   count_next;
    logic            last;

    // BPC chained bit-steps per clock, consuming the word from its MSB downward.
    always_comb begin
        rem_next = rem_out;
        step_fb  = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            step_fb  = word_reg[K-1-i] ^ rem_next[0];
            rem_next = {step_fb, rem_next[W-1:1] ^ (POLY[W-2:0] & {(W-1){step_fb}})};
        end
    end

    assign count_next = count + BPC_C;
    assign last       = (count_next == K_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            word_reg  <= '0;
            rem_out   <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rem_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        word_reg  <= data_in;
                        rem_out   <= INIT;
                        count     <= '0;
                        busy      <= 1'b1;
                        rem_zero  <= 1'b0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    rem_out  <= rem_next;
                    word_reg <= word_reg << BPC;
                    count    <= count_next;
                    if (last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        rem_zero  <= (rem_next == '0);
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
